key_debounce_n: RTL and testbench

//  Parametrised debouncer/event generator for the board push buttons and slide switches.

---
 rtl/key_debounce_n.sv | 186 ++++++++++++++++++
 tb/tb_key_debounce_n.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_n.sv
// Debounce and event generation for board push buttons and slide switches.
// Ports: clk, rst_n, push/sw raw in; push_level/press/release/repeat/any, sw_out.
`timescale 1ns/1ps
module key_debounce_n #(
  parameter int NUM_KEYS  = 4,
  parameter int NUM_SW    = 8,
  parameter int TICK_DIV  = 500000,
  parameter int DEB_TICKS = 4,
  parameter int REP_DELAY = 50,
  parameter int REP_RATE  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] push,
  input  logic [NUM_SW-1:0]   sw,
  output logic [NUM_KEYS-1:0] push_level,
  output logic [NUM_KEYS-1:0] push_press,
  output logic [NUM_KEYS-1:0] push_release,
  output logic [NUM_KEYS-1:0] push_repeat,
  output logic                push_any,
  output logic [NUM_SW-1:0]   sw_out
);

  localparam int N    = NUM_KEYS + NUM_SW;
  localparam int PW   = $clog2(TICK_DIV);
  localparam int CW   = $clog2(DEB_TICKS + 1);
  localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEB_TICKS - 1);
  localparam logic [RW-1:0] D_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REP_RATE - 1);
  localparam bit            REP_EN = (REP_DELAY != 0);

  typedef enum logic [1:0] {
    S_REL,
    S_WAIT,
    S_REP
  } st_t;

  logic [PW-1:0] r_pcnt;
  logic          w_tick;

  assign w_tick = (r_pcnt == P_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  logic [N-1:0] w_raw;
  logic [N-1:0] r_s1;
  logic [N-1:0] r_s2;

  assign w_raw = {sw, push};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  logic [N-1:0]  r_lvl;
  logic [CW-1:0] r_cnt [N];
  logic [N-1:0]  w_flip;

  // A channel flips on the tick that completes DEB_TICKS differing samples.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < N; i++) begin
      w_flip[i] = w_tick && (r_s2[i] != r_lvl[i])
                  && (r_cnt[i] == C_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl <= '0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_lvl <= r_lvl ^ w_flip;
      if (w_tick) begin
        for (int i = 0; i < N; i++) begin
          if (r_s2[i] == r_lvl[i] || w_flip[i]) begin
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  genvar k;
  for (k = 0; k < NUM_KEYS; k++) begin : g_key
    st_t           r_st;
    logic [RW-1:0] r_rc;
    logic          r_p;
    logic          r_r;
    logic          r_t;
    logic          w_rise;
    logic          w_fall;

    assign w_rise = w_flip[k] & ~r_lvl[k];
    assign w_fall = w_flip[k] &  r_lvl[k];

    // The release branch is tested first so a falling level
    // suppresses any repeat due on the same tick.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_st <= S_REL;
        r_rc <= '0;
        r_p  <= 1'b0;
        r_r  <= 1'b0;
        r_t  <= 1'b0;
      end else begin
        r_p <= 1'b0;
        r_r <= 1'b0;
        r_t <= 1'b0;
        unique case (r_st)
          S_REL: begin
            if (w_rise) begin
              r_st <= S_WAIT;
              r_rc <= '0;
              r_p  <= 1'b1;
            end
          end
          S_WAIT: begin
            if (w_fall) begin
              r_st <= S_REL;
              r_rc <= '0;
              r_r  <= 1'b1;
            end else if (REP_EN && w_tick) begin
              if (r_rc == D_LAST) begin
                r_st <= S_REP;
                r_rc <= '0;
                r_t  <= 1'b1;
              end else begin
                r_rc <= r_rc + 1'b1;
              end
            end
          end
          S_REP: begin
            if (w_fall) begin
              r_st <= S_REL;
              r_rc <= '0;
              r_r  <= 1'b1;
            end else if (w_tick) begin
              if (r_rc == R_LAST) begin
                r_rc <= '0;
                r_t  <= 1'b1;
              end else begin
                r_rc <= r_rc + 1'b1;
              end
            end
          end
          default: begin
            r_st <= S_REL;
            r_rc <= '0;
          end
        endcase
      end
    end

    assign push_press[k]   = r_p;
    assign push_release[k] = r_r;
    assign push_repeat[k]  = r_t;
  end

  assign push_level = r_lvl[NUM_KEYS-1:0];
  assign sw_out     = r_lvl[N-1:NUM_KEYS];
  assign push_any   = |r_lvl[NUM_KEYS-1:0];

endmodule

// File: tb/tb_key_debounce_n.sv
// Bench for key_debounce_n: behavioural model compared every cycle,
// plus directed scenarios with literal timing expectations.
`timescale 1ns/1ps
module tb_key_debounce_n;

  localparam int NK = 4;
  localparam int NS = 8;
  localparam int TD = 4;
  localparam int DT = 3;
  localparam int RD = 8;
  localparam int RR = 4;
  localparam int N  = NK + NS;
  localparam int OW = 4 * NK + 1 + NS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] push = '0;
  logic [NS-1:0] sw = '0;
  logic [NK-1:0] push_level;
  logic [NK-1:0] push_press;
  logic [NK-1:0] push_release;
  logic [NK-1:0] push_repeat;
  logic          push_any;
  logic [NS-1:0] sw_out;

  always #5 clk = ~clk;

  key_debounce_n #(
    .NUM_KEYS (NK),
    .NUM_SW   (NS),
    .TICK_DIV (TD),
    .DEB_TICKS(DT),
    .REP_DELAY(RD),
    .REP_RATE (RR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .sw          (sw),
    .push_level  (push_level),
    .push_press  (push_press),
    .push_release(push_release),
    .push_repeat (push_repeat),
    .push_any    (push_any),
    .sw_out      (sw_out)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic logic [OW-1:0] outs();
    return {push_level, push_press, push_release, push_repeat,
            push_any, sw_out};
  endfunction

  // Model: samples are the raw inputs two edges back; a level flips
  // when the last DT tick samples all disagree with it; repeats fall
  // at hold-tick counts RD, RD+RR, RD+2RR, ...
  int            m_cyc;
  logic [N-1:0]  q1, q2;
  logic [DT-1:0] m_hist [N];
  logic [N-1:0]  m_lvl;
  int            m_held [NK];
  logic [NK-1:0] e_press, e_rel, e_rep;
  logic [NK-1:0] prev_push = '0;
  logic [NS-1:0] prev_sw = '0;
  logic          prev_rst = 1'b0;

  always @(negedge clk) begin
    logic [N-1:0] raw;
    logic [N-1:0] smp;
    logic [OW-1:0] exp;
    raw = {prev_sw, prev_push};
    e_press = '0;
    e_rel = '0;
    e_rep = '0;
    if (!rst_n || !prev_rst) begin
      m_cyc = 0;
      q1 = '0;
      q2 = '0;
      m_lvl = '0;
      for (int c = 0; c < N; c++) m_hist[c] = '0;
      for (int c = 0; c < NK; c++) m_held[c] = 0;
    end else begin
      smp = q2;
      q2 = q1;
      q1 = raw;
      if (m_cyc % TD == TD - 1) begin
        for (int c = 0; c < N; c++) begin
          m_hist[c] = {m_hist[c][DT-2:0], smp[c]};
          if (m_hist[c] == {DT{~m_lvl[c]}}) begin
            m_lvl[c] = ~m_lvl[c];
            if (c < NK) begin
              if (m_lvl[c]) e_press[c] = 1'b1;
              else e_rel[c] = 1'b1;
              m_held[c] = 0;
            end
          end else if (c < NK && m_lvl[c]) begin
            m_held[c]++;
            if (m_held[c] == RD ||
                (m_held[c] > RD && (m_held[c] - RD) % RR == 0))
              e_rep[c] = 1'b1;
          end
        end
      end
      m_cyc++;
    end
    prev_push = push;
    prev_sw = sw;
    prev_rst = rst_n;
    exp = {m_lvl[NK-1:0], e_press, e_rel, e_rep,
           |m_lvl[NK-1:0], m_lvl[N-1:NK]};
    chk("model", outs(), exp);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NK-1:0] ev(input int which);
    case (which)
      0: return push_press;
      1: return push_release;
      default: return push_repeat;
    endcase
  endfunction

  task automatic wait_ev(input int which, input logic [NK-1:0] m,
                         input int lim, output int n, output bit hit);
    n = 0;
    do begin
      cyc();
      n++;
    end while ((ev(which) & m) == '0 && n < lim);
    hit = (ev(which) & m) != '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n, bad, extra, first;
    bit hit;
    int reps[$];

    // 1: reset with everything held
    push = '1;
    sw = '1;
    rst_n = 1'b0;
    bad = 0;
    repeat (6) begin
      cyc();
      if (outs() != '0) bad++;
    end
    chk("reset_zero", bad, 0);
    rst_n = 1'b1;
    wait_ev(0, '1, 20, n, hit);
    chk("rst_press_lat", hit && n <= 15, 1);
    chk("rst_press_val", push_press, 4'hF);
    extra = 0;
    repeat (20) begin
      cyc();
      if (push_press != '0) extra++;
    end
    chk("rst_press_once", extra, 0);
    push = '0;
    sw = '0;
    repeat (30) cyc();

    // 2: clean press and release
    push[0] = 1'b1;
    wait_ev(0, 4'b0001, 20, n, hit);
    chk("t2_press_lat", hit && n <= 15, 1);
    chk("t2_level", push_level, 4'b0001);
    extra = 0;
    repeat (20) begin
      cyc();
      if (push_press != '0 || push_repeat != '0) extra++;
    end
    chk("t2_no_extra", extra, 0);
    push[0] = 1'b0;
    wait_ev(1, 4'b0001, 20, n, hit);
    chk("t2_rel_lat", hit && n <= 15, 1);
    chk("t2_level_low", push_level, 4'b0000);
    repeat (10) cyc();

    // 3: bounce shorter than the filter
    bad = 0;
    repeat (20) begin
      push[1] = ~push[1];
      repeat (3) begin
        cyc();
        bad += int'(push_level[1] | push_press[1] | push_release[1]);
      end
    end
    push[1] = 1'b0;
    repeat (20) begin
      cyc();
      bad += int'(push_level[1] | push_press[1] | push_release[1]);
    end
    chk("t3_bounce", bad, 0);

    // 4: auto-repeat
    push[2] = 1'b1;
    wait_ev(0, 4'b0100, 20, n, hit);
    chk("t4_press", hit, 1);
    n = 0;
    repeat (120) begin
      cyc();
      n++;
      if (push_repeat[2]) reps.push_back(n);
    end
    chk("t4_reps_in_120", reps.size(), 6);
    first = (reps.size() > 0) ? reps[0] : -1;
    chk("t4_first", first, 32);
    first = (reps.size() > 1) ? reps[1] : -1;
    chk("t4_second", first, 48);
    push[2] = 1'b0;
    hit = 0;
    repeat (30) begin
      if (!hit) begin
        cyc();
        n++;
        if (push_repeat[2]) reps.push_back(n);
        if (push_release[2]) hit = 1;
      end
    end
    chk("t4_release", hit, 1);
    bad = 0;
    foreach (reps[i]) if (reps[i] != 32 + 16 * i) bad++;
    chk("t4_spacing", bad, 0);
    extra = 0;
    repeat (40) begin
      cyc();
      if (push_repeat != '0 || push_press != '0) extra++;
    end
    chk("t4_quiet_after", extra, 0);

    // 5: simultaneous channels
    push = 4'b1001;
    sw = 8'hA5;
    wait_ev(0, '1, 20, n, hit);
    chk("t5_press", push_press, 4'b1001);
    chk("t5_sw", sw_out, 8'hA5);
    cyc();
    chk("t5_any", push_any, 1);
    chk("t5_press_gone", push_press, 4'b0000);
    push = '0;
    repeat (30) cyc();

    // 6: reset during repeat phase
    push[3] = 1'b1;
    wait_ev(0, 4'b1000, 20, n, hit);
    chk("t6_press", hit, 1);
    repeat (40) cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_zero_now", outs(), '0);
    bad = 0;
    repeat (3) begin
      cyc();
      if (outs() != '0) bad++;
    end
    chk("t6_no_release", bad, 0);
    rst_n = 1'b1;
    wait_ev(0, '1, 20, n, hit);
    chk("t6_press_lat", hit && n <= 15, 1);
    chk("t6_press_val", push_press, 4'b1000);
    wait_ev(2, 4'b1000, 40, n, hit);
    chk("t6_rep_restart", hit ? n : -1, 32);
    push = '0;
    repeat (30) cyc();

    // random phase, including a short reset
    for (int i = 0; i < 3000; i++) begin
      cyc();
      for (int c = 0; c < NK; c++)
        if ($urandom_range(0, (i < 1500) ? 39 : 149) == 0)
          push[c] = ~push[c];
      for (int c = 0; c < NS; c++)
        if ($urandom_range(0, (i < 1500) ? 7 : 60) == 0)
          sw[c] = ~sw[c];
      if (i == 1500) rst_n = 1'b0;
      if (i == 1503) rst_n = 1'b1;
    end
    repeat (5) cyc();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
